fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RV32 pipeline.
- Generates the PC and runs a req/ack handshake with instruction memory. Outputs InstrD, PCD, PCPlus4D and ValidD; InstrD feeds the decode controller's OP/funct3/funct7 fields.
- Handles stalls with a one-entry skid buffer. Handles branch/jump redirects, including discarding an in-flight fetch.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request, registered
imem_addr  out  XLEN  fetch address, registered, stable while imem_req=1
imem_ack  in  1  response valid; may arrive in the same cycle as the request (zero-wait)
imem_rdata  in  32  instruction, valid with imem_ack
StallF  in  1  block issue of new requests
StallD  in  1  hold IF/ID register
FlushD  in  1  bubble the IF/ID register
PCSrcE  in  1  redirect taken (branch/jump from EX)
PCTargetE  in  XLEN  redirect target
InstrD  out  32  decoded-stage instruction
PCD  out  XLEN  PC of InstrD
PCPlus4D  out  XLEN  PCD+4
ValidD  out  1  InstrD is a real instruction
BusyF  out  1  request outstanding (state != IDLE)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - imem_req=0, imem_addr=RESET_PC, state=IDLE.
  - Skid buffer empty.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
- Protocol: at most one outstanding request. Once imem_req=1, req and addr are held until imem_ack. All PC arithmetic is modulo 2^XLEN; wrap at 32'hFFFF_FFFC→0 is silent.
- States:
  - IDLE:
    - req=0.
    - If PCSrcE: imem_addr←PCTargetE and the buffer is cleared.
    - Next state is WAIT when !StallF && buffer empty, else IDLE.
  - WAIT, no ack:
    - If PCSrcE: latch PCTargetE into redir_pc, go to DROP.
  - WAIT, ack:
    - If PCSrcE the same cycle: discard data, imem_addr←PCTargetE.
    - Otherwise: deliver data with PC=imem_addr, imem_addr←imem_addr+4.
    - Next state is WAIT if !StallF && the data did not go to the buffer, else IDLE.
  - DROP:
    - req stays 1 on the old address.
    - PCSrcE overwrites redir_pc (newest wins).
    - On ack: discard data, imem_addr←redir_pc (or PCTargetE if PCSrcE this cycle), then WAIT/IDLE by the same StallF rule.
- Delivery:
  - If !StallD and the buffer is empty, data goes straight to IF/ID.
  - Otherwise data goes to the skid buffer. The buffer is never written while valid, because no request is issued unless the buffer is empty.
- IF/ID update each edge, priority order:
  - FlushD or PCSrcE → InstrD=NOP_INSTR, ValidD=0; PCD/PCPlus4D don't care (hold).
  - StallD → hold all.
  - Buffer valid → load buffer, buffer empties.
  - Deliverable ack → load imem_rdata, PC, PC+4, ValidD=1.
  - Otherwise → bubble (ValidD=0, InstrD=NOP_INSTR).
- Latency: ack in cycle N → InstrD/ValidD visible in N+1. Zero-wait memory sustains 1 instr/cycle.
- StallF during WAIT: the outstanding request completes; only new issue is blocked.
- Reset mid-request: all state is cleared immediately. A later stray ack while IDLE is ignored.

Decomposition:
- Package rv_pipe_pkg: XLEN, NOP_INSTR, RESET_PC default, enum fetch_state_t {IDLE, WAIT, DROP}, struct if_id_t {instr, pc, pc_plus4, valid}.
- One sub-module, fetch_skid_buf: one-entry if_id_t holding register with push/pop/clear and valid flag.

Test Plan:
- Reset release, zero-wait ack every cycle → imem_addr 0,4,8,C on consecutive cycles; PCD follows one cycle behind, ValidD=1 from cycle 2.
- Ack delayed 3 cycles → imem_req/imem_addr=0x0 held stable for 3 cycles; InstrD loads one cycle after ack, bubbles (NOP_INSTR, ValidD=0) meanwhile.
- PCSrcE=1, PCTargetE=0x100 while WAIT on 0x8 with no ack → DROP; data for 0x8 is discarded on ack; next request is 0x100, and its instruction reaches InstrD with PCD=0x100, PCPlus4D=0x104.
- StallD=StallF=1 for 2 cycles while the ack for 0xC arrives → InstrD holds; 0xC is buffered with no new request. After release, InstrD=instr@0xC and the next request is 0x10.
- FlushD and StallD asserted together → InstrD=0x00000013, ValidD=0 (flush wins).
- rst_n pulsed low mid-WAIT at addr 0x20 → outputs return to reset values asynchronously; first request after release is RESET_PC.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the RV32 5-stage pipeline front end.
package rv_pipe_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEF = '0;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DROP
   } fetch_state_t;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic            valid;
   } if_id_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched instruction that could not enter IF/ID.
module fetch_skid_buf
   import rv_pipe_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  logic   pop,
   input  logic   clear,
   input  if_id_t din,
   output if_id_t dout,
   output logic   valid
);

   if_id_t data_q;
   logic   valid_q;

   // A push never meets a full entry: requests are only issued while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (clear) begin
         valid_q <= 1'b0;
      end else if (push) begin
         valid_q <= 1'b1;
         data_q  <= din;
      end else if (pop) begin
         valid_q <= 1'b0;
      end
   end

   assign dout  = data_q;
   assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with req/ack memory handshake, redirect handling and IF/ID register.
module fetch_stage
   import rv_pipe_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   input  logic            StallF,
   input  logic            StallD,
   input  logic            FlushD,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   output logic [31:0]     InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic            ValidD,
   output logic            BusyF
);

   fetch_state_t    state_q;
   logic            req_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] redir_q;
   if_id_t          ifid_q;

   if_id_t pkt;
   if_id_t buf_dout;
   logic   buf_valid;
   logic   deliver;
   logic   direct;
   logic   push;
   logic   pop;
   logic   issue;

   always_comb begin
      pkt     = '{instr: imem_rdata, pc: addr_q, pc_plus4: addr_q + 32'd4, valid: 1'b1};
      deliver = (state_q == WAIT) && imem_ack && !PCSrcE;
      direct  = deliver && !StallD && !buf_valid;
      push    = deliver && !direct;
      pop     = buf_valid && !StallD && !FlushD && !PCSrcE;
      // New requests only when the buffer will be empty after this edge.
      issue   = !StallF && !push && (!buf_valid || pop || PCSrcE);
   end

   fetch_skid_buf u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .clear (PCSrcE),
      .din   (pkt),
      .dout  (buf_dout),
      .valid (buf_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         addr_q  <= RESET_PC;
         redir_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (PCSrcE) addr_q <= PCTargetE;
               state_q <= issue ? WAIT : IDLE;
               req_q   <= issue;
            end
            WAIT: begin
               if (imem_ack) begin
                  addr_q  <= PCSrcE ? PCTargetE : addr_q + 32'd4;
                  state_q <= issue ? WAIT : IDLE;
                  req_q   <= issue;
               end else if (PCSrcE) begin
                  redir_q <= PCTargetE;
                  state_q <= DROP;
               end
            end
            DROP: begin
               // The stale response is swallowed; newest redirect wins.
               if (imem_ack) begin
                  addr_q  <= PCSrcE ? PCTargetE : redir_q;
                  state_q <= issue ? WAIT : IDLE;
                  req_q   <= issue;
               end else if (PCSrcE) begin
                  redir_q <= PCTargetE;
               end
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifid_q <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};
      end else if (FlushD || PCSrcE) begin
         ifid_q.instr <= NOP_INSTR;
         ifid_q.valid <= 1'b0;
      end else if (!StallD) begin
         if (buf_valid) begin
            ifid_q <= buf_dout;
         end else if (direct) begin
            ifid_q <= pkt;
         end else begin
            ifid_q.instr <= NOP_INSTR;
            ifid_q.valid <= 1'b0;
         end
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign InstrD    = ifid_q.instr;
   assign PCD       = ifid_q.pc;
   assign PCPlus4D  = ifid_q.pc_plus4;
   assign ValidD    = ifid_q.valid;
   assign BusyF     = (state_q != IDLE);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against a transaction-level model.
module tb_fetch_stage;
   import rv_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
   logic [31:0] PCTargetE = '0;
   logic [31:0] InstrD, PCD, PCPlus4D;
   logic        ValidD, BusyF;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(32'h0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .StallF     (StallF),
      .StallD     (StallD),
      .FlushD     (FlushD),
      .PCSrcE     (PCSrcE),
      .PCTargetE  (PCTargetE),
      .InstrD     (InstrD),
      .PCD        (PCD),
      .PCPlus4D   (PCPlus4D),
      .ValidD     (ValidD),
      .BusyF      (BusyF)
   );

   int total = 0;
   int bad = 0;

   // Model: outstanding flag, stale-response flag, fetch PC, pending redirect,
   // a queue of parked instructions and the decode-stage slot.
   bit          m_busy, m_drop;
   logic [31:0] m_pc, m_redir;
   if_id_t      m_ifid;
   if_id_t      m_buf[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0;
      m_drop = 1'b0;
      m_pc = 32'h0;
      m_redir = 32'h0;
      m_ifid = '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};
      m_buf.delete();
   endtask

   task automatic step(input bit sf, input bit sd, input bit fd, input bit ps,
                       input logic [31:0] tgt, input bit ak);
      bit acc = m_busy && ak;
      bit dlv = acc && !m_drop && !ps;
      bit direct = dlv && !sd && (m_buf.size() == 0);
      if_id_t item = '{instr: mem_word(m_pc), pc: m_pc, pc_plus4: m_pc + 32'd4, valid: 1'b1};
      if (fd || ps) begin
         m_ifid.instr = NOP_INSTR;
         m_ifid.valid = 1'b0;
      end else if (!sd) begin
         if (m_buf.size() > 0) m_ifid = m_buf.pop_front();
         else if (direct) m_ifid = item;
         else begin
            m_ifid.instr = NOP_INSTR;
            m_ifid.valid = 1'b0;
         end
      end
      if (ps) m_buf.delete();
      if (dlv && !direct) m_buf.push_back(item);
      if (!m_busy || acc) begin
         if (!m_busy) begin
            if (ps) m_pc = tgt;
         end else if (m_drop) m_pc = ps ? tgt : m_redir;
         else m_pc = ps ? tgt : m_pc + 32'd4;
         m_drop = 1'b0;
         m_busy = !sf && (m_buf.size() == 0);
      end else if (ps) begin
         m_drop = 1'b1;
         m_redir = tgt;
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic cycle(input bit sf, input bit sd, input bit fd, input bit ps,
                        input logic [31:0] tgt, input bit ak);
      StallF = sf;
      StallD = sd;
      FlushD = fd;
      PCSrcE = ps;
      PCTargetE = tgt;
      imem_ack = ak;
      imem_rdata = mem_word(m_pc);
      #1;
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_busy});
      chk("imem_addr", imem_addr, m_pc);
      chk("BusyF", {31'b0, BusyF}, {31'b0, m_busy});
      chk("InstrD", InstrD, m_ifid.instr);
      chk("PCD", PCD, m_ifid.pc);
      chk("PCPlus4D", PCPlus4D, m_ifid.pc_plus4);
      chk("ValidD", {31'b0, ValidD}, {31'b0, m_ifid.valid});
      step(sf, sd, fd, ps, tgt, ak);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      imem_ack = 1'b0;
      StallF = 1'b0;
      StallD = 1'b0;
      FlushD = 1'b0;
      PCSrcE = 1'b0;
      #2;
      model_reset();
      chk("rst_req", {31'b0, imem_req}, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_instr", InstrD, 32'h0000_0013);
      chk("rst_pcd", PCD, 32'h0);
      chk("rst_pcp4", PCPlus4D, 32'h0);
      chk("rst_valid", {31'b0, ValidD}, 32'h0);
      chk("rst_busy", {31'b0, BusyF}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1;
      do_reset();

      // Zero-wait memory streams one instruction per cycle.
      cycle(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         chk("zw_addr", imem_addr, 32'(i * 4));
         cycle(0, 0, 0, 0, 0, 1);
      end
      chk("zw_pcd", PCD, 32'hC);
      chk("zw_valid", {31'b0, ValidD}, 32'h1);

      // Slow memory: request held, decode bubbles until ack.
      do_reset();
      cycle(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         chk("slow_addr", imem_addr, 32'h0);
         chk("slow_req", {31'b0, imem_req}, 32'h1);
         chk("slow_valid", {31'b0, ValidD}, 32'h0);
         cycle(0, 0, 0, 0, 0, 0);
      end
      cycle(0, 0, 0, 0, 0, 1);
      chk("slow_instr", InstrD, mem_word(32'h0));
      chk("slow_valid1", {31'b0, ValidD}, 32'h1);

      // Redirect while waiting on 0x8: stale response dropped.
      do_reset();
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 1, 32'h100, 0);
      chk("drop_busy", {31'b0, BusyF}, 32'h1);
      chk("drop_addr", imem_addr, 32'h8);
      cycle(0, 0, 0, 0, 0, 1);
      chk("redir_addr", imem_addr, 32'h100);
      chk("redir_bubble", {31'b0, ValidD}, 32'h0);
      cycle(0, 0, 0, 0, 0, 1);
      chk("redir_pcd", PCD, 32'h100);
      chk("redir_pcp4", PCPlus4D, 32'h104);
      chk("redir_instr", InstrD, mem_word(32'h100));

      // Stall while the 0xC response lands in the skid buffer.
      do_reset();
      cycle(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1);
      cycle(1, 1, 0, 0, 0, 1);
      chk("stall_hold", InstrD, mem_word(32'h8));
      chk("stall_noreq", {31'b0, imem_req}, 32'h0);
      cycle(1, 1, 0, 0, 0, 0);
      chk("stall_hold2", InstrD, mem_word(32'h8));
      cycle(0, 0, 0, 0, 0, 0);
      chk("skid_instr", InstrD, mem_word(32'hC));
      chk("skid_pcd", PCD, 32'hC);
      chk("skid_next", imem_addr, 32'h10);
      chk("skid_req", {31'b0, imem_req}, 32'h1);

      // Flush beats stall.
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 1, 1, 0, 0, 0);
      chk("flush_instr", InstrD, 32'h0000_0013);
      chk("flush_valid", {31'b0, ValidD}, 32'h0);

      // Asynchronous reset while waiting on 0x20.
      do_reset();
      cycle(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0, 1);
      chk("mid_addr", imem_addr, 32'h20);
      chk("mid_req", {31'b0, imem_req}, 32'h1);
      #2;
      do_reset();
      cycle(0, 0, 0, 0, 0, 1);
      chk("post_rst_addr", imem_addr, 32'h0);
      chk("post_rst_req", {31'b0, imem_req}, 32'h1);

      // Randomized traffic including stray acks, stalls, flushes and redirects.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         bit sf = ($urandom_range(99) < 20);
         bit sd = ($urandom_range(99) < 20);
         bit fd = ($urandom_range(99) < 8);
         bit ps = ($urandom_range(99) < 8);
         logic [31:0] tgt = $urandom & 32'hFFFF_FFFC;
         bit ak = m_busy ? ($urandom_range(99) < 55) : ($urandom_range(99) < 10);
         if (n % 500 == 250) tgt = 32'hFFFF_FFF8;
         cycle(sf, sd, fd, ps, tgt, ak);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
